// File: rtl/flex_sample_counter_pkg.sv
// -----------------------------------------------------------------------------
// flex_counter_pkg
//   Shared types and default widths for the flexible sample counter slice.
//   mode_t selects between continuous wrapping and one-shot counting.
// -----------------------------------------------------------------------------
package flex_counter_pkg;

    typedef enum logic {
        MODE_WRAP    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_t;

    localparam int unsigned DEF_NUM_BITS = 10;
    localparam int unsigned DEF_EVT_BITS = 8;

endpackage : flex_counter_pkg

// File: rtl/flex_sample_counter_if.sv
// -----------------------------------------------------------------------------
// flex_sample_counter_if
//   Control/status bundle between a sample-strobe source (master) and the
//   flexible sample counter (slave).
//   master drives : clear, count_enable, mode, rollover_val
//   slave drives  : count_out, rollover_flag, block_done, block_count
// -----------------------------------------------------------------------------
interface flex_sample_counter_if
    import flex_counter_pkg::*;
#(
    parameter int unsigned NUM_BITS = DEF_NUM_BITS,
    parameter int unsigned EVT_BITS = DEF_EVT_BITS
) ();

    logic                clear;
    logic                count_enable;
    mode_t               mode;
    logic [NUM_BITS-1:0] rollover_val;
    logic [NUM_BITS-1:0] count_out;
    logic                rollover_flag;
    logic                block_done;
    logic [EVT_BITS-1:0] block_count;

    modport master (
        output clear, count_enable, mode, rollover_val,
        input  count_out, rollover_flag, block_done, block_count
    );

    modport slave (
        input  clear, count_enable, mode, rollover_val,
        output count_out, rollover_flag, block_done, block_count
    );

endinterface : flex_sample_counter_if

// File: rtl/flex_sample_counter_sat_event_counter.sv
// -----------------------------------------------------------------------------
// sat_event_counter
//   Saturating event tally: adds one per cycle with inc high, sticks at
//   all-ones. Only reset returns it to zero.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   inc   : increment request (one event per cycle)
//   count : registered tally
// -----------------------------------------------------------------------------
module sat_event_counter
    import flex_counter_pkg::*;
#(
    parameter int unsigned EVT_BITS = DEF_EVT_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    output logic [EVT_BITS-1:0] count
);

    localparam logic [EVT_BITS-1:0] CNT_MAX = {EVT_BITS{1'b1}};
    localparam logic [EVT_BITS-1:0] CNT_ONE = EVT_BITS'(1);

    logic [EVT_BITS-1:0] count_q;
    logic [EVT_BITS-1:0] count_d;

    // Next tally: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Tally register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_event_counter

// File: rtl/flex_sample_counter.sv
// -----------------------------------------------------------------------------
// flex_sample_counter
//   Counts qualified sample strobes up to a programmable terminal count R
//   (rollover_val). WRAP mode runs 0,1..R,1..R,... with no dead cycle between
//   periods; ONESHOT mode stops and holds at R until cleared. Reports the
//   terminal count as a level (rollover_flag) and as a one-cycle pulse on
//   entry (block_done), and keeps a saturating tally of completed blocks.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (highest priority)
//   bus   : slave side of flex_sample_counter_if
//           in : clear, count_enable, mode, rollover_val
//           out: count_out, rollover_flag, block_done, block_count
// -----------------------------------------------------------------------------
module flex_sample_counter
    import flex_counter_pkg::*;
#(
    parameter int unsigned NUM_BITS = DEF_NUM_BITS,
    parameter int unsigned EVT_BITS = DEF_EVT_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    flex_sample_counter_if.slave bus
);

    localparam logic [NUM_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_BITS-1:0] CNT_ONE  = NUM_BITS'(1);

    logic [NUM_BITS-1:0] count_q;
    logic [NUM_BITS-1:0] count_d;
    logic                flag_q;
    logic                flag_d;
    logic                done_q;
    logic                done_d;
    logic [EVT_BITS-1:0] tally_s;
    logic [NUM_BITS-1:0] term_s;
    logic                active_s;

    assign term_s   = bus.rollover_val;
    // R == 0 disables counting entirely.
    assign active_s = bus.count_enable && (term_s != CNT_ZERO);

    // Next-count and terminal-pulse decision.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (bus.clear) begin
            count_d = CNT_ZERO;
            done_d  = 1'b0;
        end else if (active_s) begin
            if (count_q < term_s) begin
                // count_q < R guarantees the increment cannot overflow.
                count_d = count_q + CNT_ONE;
                done_d  = ((count_q + CNT_ONE) == term_s);
            end else if (count_q == term_s) begin
                if (bus.mode == MODE_WRAP) begin
                    // Restart at 1; with R == 1 that re-enters R and is a
                    // completed block of its own.
                    count_d = CNT_ONE;
                    done_d  = (term_s == CNT_ONE);
                end else begin
                    count_d = count_q;
                    done_d  = 1'b0;
                end
            end else begin
                // Out of range after R was lowered: resync without a pulse.
                if (bus.mode == MODE_ONESHOT) begin
                    count_d = term_s;
                end else begin
                    count_d = CNT_ONE;
                end
                done_d = 1'b0;
            end
        end else begin
            count_d = count_q;
            done_d  = 1'b0;
        end
    end

    // Level flag tracks the count that will be held after this edge against
    // the R presented now, so an R change alone updates it one edge later.
    always_comb begin
        flag_d = 1'b0;
        if (bus.clear) begin
            flag_d = 1'b0;
        end else begin
            flag_d = (count_d == term_s) && (term_s != CNT_ZERO);
        end
    end

    // Count, flag and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CNT_ZERO;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
        end
    end

    // Tally advances on the same edge that raises block_done.
    sat_event_counter #(
        .EVT_BITS (EVT_BITS)
    ) u_tally (
        .clk   (clk),
        .reset (reset),
        .inc   (done_d),
        .count (tally_s)
    );

    assign bus.count_out     = count_q;
    assign bus.rollover_flag = flag_q;
    assign bus.block_done    = done_q;
    assign bus.block_count   = tally_s;

endmodule : flex_sample_counter
